sg: RTL and testbench
=====================

SG -- requirements
Module: sg

Interface
REQ-001 The module SHALL have the parameter PHASE_W, default 20, meaning the width of the phase accumulator and of phi_inc_i.
REQ-002 The module SHALL have the parameter OUT_W, default 20, meaning the width of the signed sine/cosine outputs.
REQ-003 The module SHALL have the parameter CORDIC_ITER, default 18, meaning the number of pipelined CORDIC rotation stages.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: synchronous reset, active-high; reset is applied at a rising clk edge while reset_n=1.
REQ-006 The module SHALL have port clken, input, 1 bit: clock enable; when 0, all state holds.
REQ-007 The module SHALL have port phi_inc_i, input, PHASE_W bits: unsigned phase increment, sampled every enabled cycle.
REQ-008 The module SHALL have port fsin_o, output, OUT_W bits: two's-complement sine sample, registered.
REQ-009 The module SHALL have port fcos_o, output, OUT_W bits: two's-complement cosine sample, registered.
REQ-010 The module SHALL have port out_valid, output, 1 bit: high when fsin_o/fcos_o hold valid samples, registered.

Function
REQ-011 The phase accumulator acc (PHASE_W bits, unsigned) SHALL update acc <= acc + phi_inc_i modulo 2^PHASE_W on every enabled, non-reset cycle.
REQ-012 Phase wrap-around SHALL be silent modular overflow, with no saturation and no flag.
REQ-013 Output sample k (k = 0 is the first sample after reset release) SHALL correspond to phase p_k = k * phi_inc_i mod 2^20, with phi_inc_i held constant.
REQ-014 fsin_o SHALL be within ±8 LSB of round(A*sin(2*pi*p_k/2^20)), with A = 2^19-1.
REQ-015 fcos_o SHALL be within ±8 LSB of round(A*cos(2*pi*p_k/2^20)), with A = 2^19-1.
REQ-016 Outputs SHALL never exceed ±(2^19-1); internal results SHALL be saturated to this range, so -2^19 is never emitted.
REQ-017 Computation SHALL use the two MSBs of the phase for quadrant folding into [-pi/4, pi/4] or equivalent, followed by CORDIC_ITER pipelined CORDIC rotation stages.
REQ-018 CORDIC stages SHALL use an internal datapath of at least 24 bits, with arctan constants as fixed ROM values and the CORDIC gain pre-compensated in the initial x value.
REQ-019 The pipeline latency from an acc value to its registered output SHALL be exactly L = CORDIC_ITER + 2 enabled cycles (20 with defaults).
REQ-020 A change of phi_inc_i SHALL take effect on the next enabled edge, and outputs SHALL reflect the change L enabled cycles later, with no glitch or invalid flag.
REQ-021 While clken=0, the accumulator, all pipeline registers, the valid counter, and all outputs SHALL hold their values.
REQ-022 out_valid SHALL rise after exactly L enabled cycles following reset release and SHALL then stay 1 until the next reset.
REQ-023 Disabled cycles (clken=0) SHALL NOT count toward L.
REQ-024 Reset SHALL take priority over clken.

Reset
REQ-025 When reset is applied, acc, all pipeline registers, fsin_o, fcos_o and out_valid SHALL be cleared to 0 on that edge, regardless of clken.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight samples, and out_valid SHALL drop to 0 on the same edge.
REQ-027 After any reset, the first valid sample SHALL again be k = 0 (phase 0).

Verification
REQ-028 Bench SHALL check: phi_inc_i=0x2AAAB, clken=1, reset released -> out_valid rises after 20 cycles; fsin_o ≈ 0, 454046, 454046, 0, -454046, -454046 repeating; fcos_o ≈ 524287, 262144, -262143, -524287, -262143, 262144 (±8 LSB).
REQ-029 Bench SHALL check: phi_inc_i=0 -> constant fsin_o ≈ 0 and fcos_o ≈ 524287 once out_valid=1.
REQ-030 Bench SHALL check: phi_inc_i=0x40000 (quarter turn) -> sin sequence 0, 524287, 0, -524287 and cos sequence 524287, 0, -524287, 0 (±8 LSB); no output reaches -524288.
REQ-031 Bench SHALL check: clken toggled randomly -> output sample sequence identical to the clken=1 run, with out_valid onset after 20 enabled cycles.
REQ-032 Bench SHALL check: reset asserted for 1 cycle mid-stream -> outputs and out_valid read 0 on the next edge, and the sequence restarts from phase 0 with 20-cycle latency.
REQ-033 Bench SHALL check: phi_inc_i=0xFFFFF (wraps every cycle) -> outputs track phase -k modulo 2^20, i.e. fsin_o slowly negative-decreasing from 0, all within ±8 LSB.

Source files
------------

// File: rtl/sg.sv
// Sine/cosine generator: phase accumulator, nearest-quadrant fold, pipelined CORDIC
// rotator and a round/saturate output register. Accumulator-to-output latency is CORDIC_ITER + 2.
module sg #(
  parameter int unsigned PHASE_W     = 20,
  parameter int unsigned OUT_W       = 20,
  parameter int unsigned CORDIC_ITER = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clken,
  input  logic [PHASE_W-1:0] phi_inc_i,
  output logic [OUT_W-1:0]   fsin_o,
  output logic [OUT_W-1:0]   fcos_o,
  output logic               out_valid
);

  localparam int unsigned GW  = 6;                 // fractional guard bits below the output LSB
  localparam int unsigned DW  = OUT_W + GW + 2;
  localparam int unsigned ZW  = 32;                // angle unit: one full turn = 2^32
  localparam int unsigned LAT = CORDIC_ITER + 2;
  localparam int unsigned CW  = $clog2(LAT + 1);
  localparam real         KINV = 0.6072529350088812;

  localparam logic signed [DW-1:0] X0 =
    DW'(longint'(((2.0 ** (OUT_W - 1)) - 1.0) * (2.0 ** GW) * KINV));
  localparam logic signed [DW-1:0] OUT_MAX = DW'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] OUT_MIN = -OUT_MAX;
  localparam logic signed [DW-1:0] RND     = DW'(longint'(1) << (GW - 1));

  // atan(2^-i) expressed in turns scaled by 2^32
  function automatic logic [ZW-1:0] atan_rom(input int unsigned i);
    case (i)
      0:       return 32'h2000_0000;
      1:       return 32'h12E4_051E;
      2:       return 32'h09FB_385B;
      3:       return 32'h0511_11D4;
      4:       return 32'h028B_0D43;
      5:       return 32'h0145_D7E1;
      6:       return 32'h00A2_F61E;
      7:       return 32'h0051_7C55;
      8:       return 32'h0028_BE53;
      9:       return 32'h0014_5F2F;
      10:      return 32'h000A_2F98;
      11:      return 32'h0005_17CC;
      12:      return 32'h0002_8BE6;
      13:      return 32'h0001_45F3;
      14:      return 32'h0000_A2FA;
      15:      return 32'h0000_517D;
      16:      return 32'h0000_28BE;
      17:      return 32'h0000_145F;
      18:      return 32'h0000_0A30;
      19:      return 32'h0000_0518;
      20:      return 32'h0000_028C;
      21:      return 32'h0000_0146;
      22:      return 32'h0000_00A3;
      23:      return 32'h0000_0051;
      default: return '0;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] round_sat(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] r;
    r = (v + RND) >>> GW;
    if (r > OUT_MAX) r = OUT_MAX;
    else if (r < OUT_MIN) r = OUT_MIN;
    return r[OUT_W-1:0];
  endfunction

  logic [PHASE_W-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 valid_q;
  logic [OUT_W-1:0]     sin_q, sin_d;
  logic [OUT_W-1:0]     cos_q, cos_d;

  logic signed [DW-1:0] x_q [0:CORDIC_ITER];
  logic signed [DW-1:0] y_q [0:CORDIC_ITER];
  logic signed [DW-1:0] x_d [0:CORDIC_ITER];
  logic signed [DW-1:0] y_d [0:CORDIC_ITER];
  logic signed [ZW-1:0] z_q [0:CORDIC_ITER-1];
  logic signed [ZW-1:0] z_d [0:CORDIC_ITER-1];

  logic [1:0]           quad;
  logic [PHASE_W-1:0]   ph_res;

  // Fold: pick the nearest quadrant so the residual lies in [-1/8, 1/8) turn,
  // and start the vector already rotated by that quadrant.
  always_comb begin
    quad   = 2'((acc_q + (PHASE_W'(1) << (PHASE_W - 3))) >> (PHASE_W - 2));
    ph_res = acc_q - (PHASE_W'(quad) << (PHASE_W - 2));
    z_d[0] = ZW'(signed'(ph_res)) <<< (ZW - PHASE_W);
    case (quad)
      2'd0:    begin x_d[0] = X0;  y_d[0] = '0;  end
      2'd1:    begin x_d[0] = '0;  y_d[0] = X0;  end
      2'd2:    begin x_d[0] = -X0; y_d[0] = '0;  end
      default: begin x_d[0] = '0;  y_d[0] = -X0; end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < CORDIC_ITER; i++) begin
      if (!z_q[i][ZW-1]) begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
      end else begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end
    end
    for (int unsigned i = 1; i < CORDIC_ITER; i++) begin
      if (!z_q[i-1][ZW-1]) z_d[i] = z_q[i-1] - signed'(atan_rom(i - 1));
      else                 z_d[i] = z_q[i-1] + signed'(atan_rom(i - 1));
    end
  end

  always_comb begin
    cos_d = round_sat(x_q[CORDIC_ITER]);
    sin_d = round_sat(y_q[CORDIC_ITER]);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      for (int unsigned i = 0; i <= CORDIC_ITER; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      for (int unsigned i = 0; i < CORDIC_ITER; i++) z_q[i] <= '0;
    end else if (clken) begin
      acc_q <= acc_q + phi_inc_i;
      for (int unsigned i = 0; i <= CORDIC_ITER; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      for (int unsigned i = 0; i < CORDIC_ITER; i++) z_q[i] <= z_d[i];
      sin_q <= sin_d;
      cos_q <= cos_d;
      if (!valid_q) begin
        if (cnt_q == CW'(LAT - 1)) valid_q <= 1'b1;
        else                       cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  assign fsin_o    = sin_q;
  assign fcos_o    = cos_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sg.sv
// Self-checking bench for sg: reference model maps each enabled cycle to a phase
// k*inc and compares outputs against real-valued sin/cos with tolerance.
module tb_sg;

  localparam int  L   = 20;
  localparam int  A   = 524287;
  localparam int  TOL = 8;
  localparam real PI  = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               clken;
  logic [19:0]        phi_inc_i;
  logic signed [19:0] fsin_o;
  logic signed [19:0] fcos_o;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  // model state: phases queued per enabled cycle, emitted L enabled cycles later
  int m_q[$];
  int m_phase = 0;
  bit m_valid = 1'b0;
  int m_cur   = 0;

  always #5 clk = ~clk;

  sg #(.PHASE_W(20), .OUT_W(20), .CORDIC_ITER(18)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
    .fcos_o    (fcos_o),
    .out_valid (out_valid)
  );

  function automatic int esin(input int p);
    return $rtoi($floor(A * $sin(2.0 * PI * p / 1048576.0) + 0.5));
  endfunction

  function automatic int ecos(input int p);
    return $rtoi($floor(A * $cos(2.0 * PI * p / 1048576.0) + 0.5));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      m_phase = 0;
      m_q.delete();
      m_valid = 1'b0;
    end else if (clken) begin
      m_q.push_back(m_phase);
      m_phase = (m_phase + int'(phi_inc_i)) & 32'h000F_FFFF;
      if (m_q.size() == L) begin
        m_cur   = m_q.pop_front();
        m_valid = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; clken = 1'b0; phi_inc_i = 20'h12345;
    for (int c = 0; c < 3; c++) begin
      clken = 1'(c);
      tick();
      checks++;
      if (out_valid !== 1'b0 || fsin_o !== 20'sd0 || fcos_o !== 20'sd0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got valid=%b sin=%0d cos=%0d exp 0/0/0", c, out_valid, fsin_o, fcos_o);
      end
    end
  endtask

  task automatic test_sixth_turn();
    int ts[3] = '{0, 454046, 454046};
    int tc[3] = '{524287, 262144, -262143};
    int k = 0;
    int onset = -1;
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'h2AAAB;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 44; c++) begin
      tick();
      if (onset < 0 && out_valid === 1'b1) onset = c;
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_60 cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o) - esin(m_cur)) > TOL || iabs(int'(fcos_o) - ecos(m_cur)) > TOL) begin
          errors++;
          $display("FAIL sample_60 k=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", k, fsin_o, fcos_o, esin(m_cur), ecos(m_cur));
        end
        if (k < 3) begin
          checks++;
          if (iabs(int'(fsin_o) - ts[k]) > TOL || iabs(int'(fcos_o) - tc[k]) > TOL) begin
            errors++;
            $display("FAIL table_60 k=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", k, fsin_o, fcos_o, ts[k], tc[k]);
          end
        end
        k++;
      end
    end
    checks++;
    if (onset != L) begin
      errors++; $display("FAIL onset_60 got=%0d exp=%0d", onset, L);
    end
  endtask

  task automatic test_zero_inc();
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'h0;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_zero cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o)) > TOL || iabs(int'(fcos_o) - A) > TOL) begin
          errors++; $display("FAIL const_zero cyc=%0d got sin=%0d cos=%0d exp sin=0 cos=%0d", c, fsin_o, fcos_o, A);
        end
      end
    end
  endtask

  task automatic test_quarter();
    int ts[4] = '{0, 524287, 0, -524287};
    int tc[4] = '{524287, 0, -524287, 0};
    int k = 0;
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'h40000;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_quarter cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o) - ts[k % 4]) > TOL || iabs(int'(fcos_o) - tc[k % 4]) > TOL) begin
          errors++;
          $display("FAIL table_quarter k=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", k, fsin_o, fcos_o, ts[k % 4], tc[k % 4]);
        end
        checks++;
        if (int'(fsin_o) < -A || int'(fcos_o) < -A) begin
          errors++; $display("FAIL sat_quarter k=%0d got sin=%0d cos=%0d exp >= %0d", k, fsin_o, fcos_o, -A);
        end
        k++;
      end
    end
  endtask

  task automatic test_clken_random();
    int en_cnt = 0;
    int onset = -1;
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'h2AAAB;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      clken = ($urandom_range(0, 2) != 0);
      if (clken) en_cnt++;
      tick();
      if (onset < 0 && out_valid === 1'b1) onset = en_cnt;
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_clken cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o) - esin(m_cur)) > TOL || iabs(int'(fcos_o) - ecos(m_cur)) > TOL) begin
          errors++;
          $display("FAIL sample_clken cyc=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", c, fsin_o, fcos_o, esin(m_cur), ecos(m_cur));
        end
      end
    end
    checks++;
    if (onset != L) begin
      errors++; $display("FAIL onset_clken got=%0d exp=%0d", onset, L);
    end
  endtask

  task automatic test_midstream_reset();
    int onset = -1;
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'h12345;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 30; c++) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL prereset_valid got=%b exp=1", out_valid);
    end
    reset_n = 1'b1; clken = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || fsin_o !== 20'sd0 || fcos_o !== 20'sd0) begin
      errors++; $display("FAIL midreset got valid=%b sin=%0d cos=%0d exp 0/0/0", out_valid, fsin_o, fcos_o);
    end
    reset_n = 1'b0; clken = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 28) phi_inc_i = 20'h0F0F0;
      tick();
      if (onset < 0 && out_valid === 1'b1) onset = c;
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_restart cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o) - esin(m_cur)) > TOL || iabs(int'(fcos_o) - ecos(m_cur)) > TOL) begin
          errors++;
          $display("FAIL sample_restart cyc=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", c, fsin_o, fcos_o, esin(m_cur), ecos(m_cur));
        end
      end
    end
    checks++;
    if (onset != L) begin
      errors++; $display("FAIL onset_restart got=%0d exp=%0d", onset, L);
    end
  endtask

  task automatic test_wrap();
    reset_n = 1'b1; clken = 1'b1; phi_inc_i = 20'hFFFFF;
    tick();
    reset_n = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      tick();
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL valid_wrap cyc=%0d got=%b exp=%b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (iabs(int'(fsin_o) - esin(m_cur)) > TOL || iabs(int'(fcos_o) - ecos(m_cur)) > TOL
            || int'(fsin_o) > TOL) begin
          errors++;
          $display("FAIL sample_wrap cyc=%0d got sin=%0d cos=%0d exp sin=%0d cos=%0d", c, fsin_o, fcos_o, esin(m_cur), ecos(m_cur));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sixth_turn();
    test_zero_inc();
    test_quarter();
    test_clken_random();
    test_midstream_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
